// File: rtl/pe_mac_ws_pipelined_cg.sv
// ---------------------------------------------------------------------------
// pe_mac_ws_pipelined_cg
// Weight-stationary multiply-accumulate processing element for a systolic
// array. It holds one weight, multiplies it by the pixel arriving from the
// west, and adds the product to the partial sum from the north. For K-tiling
// passes, a base partial sum from memory can be the addend instead.
// The datapath is a two-stage pipeline (product/addend, then sum). Every
// register advances only on cycles where enable_cycle is high.
//
// Optional build macro: PE_ICG_CELL_EN
//    defined   - enable_cycle feeds a latch-based clock gate. All registers
//                clock on the gated clock gclk.
//    undefined - registers clock on clk and use a synchronous hold enable.
//    Cycle behaviour is the same in both builds. rst_n acts in both builds.
//
// Ports:
//    clk                 clock
//    rst_n               asynchronous active-low reset, clears all registers
//    enable_cycle        per-cycle enable for every register
//    reset_psum          clears the product, addend and psum registers
//    load_W              capture W_in into the stationary weight
//    load_psum_from_mem  use psum_mem_in instead of psum_in as the addend
//    W_in                weight to load
//    pixel_in            activation from the west neighbour
//    psum_in             partial sum from the north neighbour
//    psum_mem_in         base partial sum from memory
//    pixel_out           registered pixel_in, forwarded east
//    psum_out            registered partial sum, forwarded south
// ---------------------------------------------------------------------------
module pe_mac_ws_pipelined_cg #(
   parameter int DATA_W      = 8,
   parameter int ACC_W       = 32,
   parameter int SIGNED_MODE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable_cycle,
   input  logic              reset_psum,
   input  logic              load_W,
   input  logic              load_psum_from_mem,
   input  logic [DATA_W-1:0] W_in,
   input  logic [DATA_W-1:0] pixel_in,
   input  logic [ACC_W-1:0]  psum_in,
   input  logic [ACC_W-1:0]  psum_mem_in,
   output logic [DATA_W-1:0] pixel_out,
   output logic [ACC_W-1:0]  psum_out
);

   localparam int PROD_W = 2 * DATA_W;

   logic [DATA_W-1:0] w_reg, w_next;
   logic [DATA_W-1:0] pixel_reg;
   logic [ACC_W-1:0]  prod_reg, prod_next;
   logic [ACC_W-1:0]  addend_reg, addend_next;
   logic [ACC_W-1:0]  psum_reg, psum_next;
   logic [ACC_W-1:0]  prod_ext;

   logic reg_clk;
   logic reg_en;

`ifdef PE_ICG_CELL_EN
   // The latch is transparent while clk is low, so the enable is stable for
   // the whole high phase and gclk cannot glitch.
   logic en_latch;
   logic gclk;

   always_latch begin
      if (!clk)
         en_latch <= enable_cycle;
   end

   assign gclk    = clk & en_latch;
   assign reg_clk = gclk;
   assign reg_en  = 1'b1;
`else
   assign reg_clk = clk;
   assign reg_en  = enable_cycle;
`endif

   // The full-width product is formed first and then extended to ACC_W.
   // Zero extension is used for unsigned mode and sign extension for signed mode.
   generate
      if (SIGNED_MODE != 0) begin : g_signed_mul
         logic signed [PROD_W-1:0] prod_full;
         assign prod_full = PROD_W'($signed(pixel_in)) * PROD_W'($signed(w_reg));
         assign prod_ext  = ACC_W'(prod_full);
      end else begin : g_unsigned_mul
         logic [PROD_W-1:0] prod_full;
         assign prod_full = PROD_W'(pixel_in) * PROD_W'(w_reg);
         assign prod_ext  = ACC_W'(prod_full);
      end
   endgenerate

   // reset_psum has the highest priority. It flushes both pipeline stages.
   // The weight and pixel registers still update normally.
   always_comb begin
      w_next      = load_W ? W_in : w_reg;
      prod_next   = prod_ext;
      addend_next = load_psum_from_mem ? psum_mem_in : psum_in;
      psum_next   = addend_reg + prod_reg;   // wraps modulo 2^ACC_W
      if (reset_psum) begin
         prod_next   = '0;
         addend_next = '0;
         psum_next   = '0;
      end
   end

   always_ff @(posedge reg_clk or negedge rst_n) begin
      if (!rst_n) begin
         w_reg      <= '0;
         pixel_reg  <= '0;
         prod_reg   <= '0;
         addend_reg <= '0;
         psum_reg   <= '0;
      end else if (reg_en) begin
         w_reg      <= w_next;
         pixel_reg  <= pixel_in;
         prod_reg   <= prod_next;
         addend_reg <= addend_next;
         psum_reg   <= psum_next;
      end
   end

   assign pixel_out = pixel_reg;
   assign psum_out  = psum_reg;

endmodule

// File: tb/tb_pe_mac_ws_pipelined_cg.sv
// ---------------------------------------------------------------------------
// Testbench for pe_mac_ws_pipelined_cg (DATA_W=8, ACC_W=32, unsigned).
// The driver applies one set of inputs per clock on the falling edge. It also
// pushes the outputs expected after the next rising edge into a queue. The
// monitor pops one entry per rising edge and compares it with the outputs.
// The expected values come from a history model. A psum result is built from
// the inputs of the previous enabled edge and the weight in effect at that
// edge. A weight load at an edge takes effect only after that edge.
// ---------------------------------------------------------------------------
module tb_pe_mac_ws_pipelined_cg;

   localparam int DW = 8;
   localparam int AW = 32;
   localparam int SM = 0;

   logic          clk;
   logic          rst_n;
   logic          enable_cycle;
   logic          reset_psum;
   logic          load_W;
   logic          load_psum_from_mem;
   logic [DW-1:0] W_in;
   logic [DW-1:0] pixel_in;
   logic [AW-1:0] psum_in;
   logic [AW-1:0] psum_mem_in;
   logic [DW-1:0] pixel_out;
   logic [AW-1:0] psum_out;

   pe_mac_ws_pipelined_cg #(
      .DATA_W      (DW),
      .ACC_W       (AW),
      .SIGNED_MODE (SM)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .enable_cycle       (enable_cycle),
      .reset_psum         (reset_psum),
      .load_W             (load_W),
      .load_psum_from_mem (load_psum_from_mem),
      .W_in               (W_in),
      .pixel_in           (pixel_in),
      .psum_in            (psum_in),
      .psum_mem_in        (psum_mem_in),
      .pixel_out          (pixel_out),
      .psum_out           (psum_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] psum;
      logic [DW-1:0] pix;
   } exp_t;

   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;
   int txn   = 0;

   // Reference model state.
   logic [DW-1:0] cur_w;       // weight currently in effect
   bit            prev_valid;  // an enabled edge occurred since reset
   bit            prev_rp;     // that edge had reset_psum
   logic [AW-1:0] prev_sum;    // addend + product from that edge
   logic [AW-1:0] exp_psum;
   logic [DW-1:0] exp_pix;

   function automatic logic [AW-1:0] mul_ext(logic [DW-1:0] a, logic [DW-1:0] b);
      longint p;
      if (SM != 0) p = longint'($signed(a)) * longint'($signed(b));
      else         p = longint'(a) * longint'(b);
      return p[AW-1:0];
   endfunction

   task automatic check(string name, logic [AW-1:0] act, logic [AW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      cur_w      = '0;
      prev_valid = 0;
      prev_rp    = 0;
      prev_sum   = '0;
      exp_psum   = '0;
      exp_pix    = '0;
   endtask

   task automatic drive(bit en, bit rp, bit lw, bit lm, logic [DW-1:0] w,
                        logic [DW-1:0] px, logic [AW-1:0] ps, logic [AW-1:0] pm);
      exp_t e;
      @(negedge clk);
      enable_cycle       = en;
      reset_psum         = rp;
      load_W             = lw;
      load_psum_from_mem = lm;
      W_in               = w;
      pixel_in           = px;
      psum_in            = ps;
      psum_mem_in        = pm;
      if (en) begin
         if (rp)
            exp_psum = '0;
         else if (prev_valid && !prev_rp)
            exp_psum = prev_sum;
         else
            exp_psum = '0;
         prev_valid = 1;
         prev_rp    = rp;
         prev_sum   = (lm ? pm : ps) + mul_ext(px, cur_w);
         if (lw) cur_w = w;
         exp_pix = px;
      end
      e.psum = exp_psum;
      e.pix  = exp_pix;
      exp_q.push_back(e);
   endtask

   // Monitor: one expectation per rising edge, compared 1ns after the edge.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         txn++;
         check("psum_out", psum_out, e.psum);
         check("pixel_out", AW'(pixel_out), AW'(e.pix));
         $display("txn %0d: psum_out=%h pixel_out=%h", txn, psum_out, pixel_out);
      end
   end

   // Stop a hung run.
   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      enable_cycle = 0; reset_psum = 0; load_W = 0; load_psum_from_mem = 0;
      W_in = '0; pixel_in = '0; psum_in = '0; psum_mem_in = '0;
      model_reset();

      #12;
      check("reset psum_out", psum_out, '0);
      check("reset pixel_out", AW'(pixel_out), '0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1. weight load
      drive(1, 0, 1, 0, 8'd10, 8'd0, 32'd0, 32'd0);
      // 2. pipelined MAC
      drive(1, 0, 0, 0, 8'd0, 8'd5, 32'd0,   32'd0);
      drive(1, 0, 0, 0, 8'd0, 8'd3, 32'd100, 32'd0);
      drive(1, 0, 0, 0, 8'd0, 8'd0, 32'd200, 32'd0);
      // 3. gated cycles, including a gated reset_psum
      drive(0, 0, 0, 0, 8'd0, 8'd8, 32'd300, 32'd0);
      drive(0, 1, 1, 1, 8'd77, 8'd8, 32'd300, 32'd9);
      // 4. accumulator reset
      drive(1, 1, 0, 0, 8'd0, 8'd0, 32'd0,  32'd0);
      drive(1, 0, 0, 0, 8'd0, 8'd2, 32'd10, 32'd0);
      drive(1, 0, 0, 0, 8'd0, 8'd4, 32'd40, 32'd0);
      drive(1, 0, 0, 0, 8'd0, 8'd0, 32'd0,  32'd0);
      // 5. tiling base from memory
      drive(1, 0, 0, 1, 8'd0, 8'd1, 32'd5, 32'hFFFF0000);
      drive(1, 0, 0, 0, 8'd0, 8'd0, 32'd0, 32'd0);
      drive(1, 0, 0, 0, 8'd0, 8'd0, 32'd0, 32'd0);
      // 6. wrap-around
      drive(1, 0, 1, 0, 8'd255, 8'd0,   32'd0, 32'd0);
      drive(1, 0, 0, 1, 8'd0,   8'd255, 32'd0, 32'hFFFFFFFF);
      drive(1, 0, 0, 0, 8'd0,   8'd0,   32'd0, 32'd0);
      drive(1, 0, 0, 0, 8'd0,   8'd0,   32'd0, 32'd0);

      // Randomized traffic with gating, clears, loads and memory base.
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
               DW'($urandom), DW'($urandom), AW'($urandom), AW'($urandom));
      end

      // Drain with gated cycles, then hit async reset between edges.
      drive(0, 0, 0, 0, 8'd0, 8'd0, 32'd0, 32'd0);
      drive(0, 0, 0, 0, 8'd0, 8'd0, 32'd0, 32'd0);
      @(posedge clk);
      #3;
      check("queue drained before reset", AW'(exp_q.size()), '0);
      rst_n = 1'b0;
      #1;
      check("async reset psum_out", psum_out, '0);
      check("async reset pixel_out", AW'(pixel_out), '0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Recovery after async reset; the weight must read back as 0.
      drive(1, 0, 0, 0, 8'd0, 8'd9, 32'd7, 32'd0);
      for (int i = 0; i < 60; i++) begin
         drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
               DW'($urandom), DW'($urandom), AW'($urandom), AW'($urandom));
      end
      drive(0, 0, 0, 0, 8'd0, 8'd0, 32'd0, 32'd0);
      @(posedge clk);
      #3;
      check("queue drained at end", AW'(exp_q.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
